fsab_client_issuer: RTL and testbench
=====================================

# fsab_client_issuer

Upstream FSAB master stage placed between a client (cache, DMA, framebuffer fetch) and its per-device port on the FSAB bus arbiter. Converts a simple ready/valid request plus a write-data stream into FSAB request beats (`fsabo_*`). Enforces credit flow control so the arbiter's per-device request FIFO never overflows, and guarantees write bursts are issued as contiguous beats.

## Interface
- `DID`, 0: device ID driven on `fsabo_did`.
- `SUBDID`, 0: sub-device ID driven on `fsabo_subdid`.
- `INITIAL_CREDITS`, 4: credits at reset; equals arbiter FIFO depth.
- `CREDITS_W`, 3: credit counter width; must hold INITIAL_CREDITS.
- `ADDR_W`, 31 / `LEN_W`, 4 / `DATA_W`, 64 / `MASK_W`, 8 / `DID_W`, 4: field widths.
- `WBUF_DEPTH`, 8: write-data buffer depth; also the maximum burst length.
- `clk`  in  1  clock.
- `Nrst`  in  1  reset. One clock; reset is asynchronous and active-low.
- `req_valid`  in  1  client request valid.
- `req_ready`  out  1  request accepted this cycle when high with `req_valid`.
- `req_write`  in  1  1 = write (FSAB_WRITE), 0 = read.
- `req_addr`  in  ADDR_W  start address.
- `req_len`  in  LEN_W  beats, legal range 1..WBUF_DEPTH.
- `wdata_valid`, `wdata_ready`  in/out  1  write-data stream handshake.
- `wdata`  in  DATA_W; `wmask`  in  MASK_W  write beat payload.
- `fsabo_valid`  out  1  beat valid to arbiter.
- `fsabo_mode`  out  1; `fsabo_did`, `fsabo_subdid`  out  DID_W; `fsabo_addr`  out  ADDR_W; `fsabo_len`  out  LEN_W; `fsabo_data`  out  DATA_W; `fsabo_mask`  out  MASK_W  FSAB beat fields.
- `fsabo_credit`  in  1  one-cycle credit-return pulse from the arbiter.
- `len_err`  out  1  one-cycle pulse: accepted request with `req_len` of 0 or greater than WBUF_DEPTH.

## Operation
- Write buffer: WBUF_DEPTH-entry FIFO of {wdata, wmask}. Uses a count register of width clog2(WBUF_DEPTH)+1.
  - `wdata_ready` = (count < WBUF_DEPTH).
  - Push and pop in the same cycle leave the count unchanged.
- Credit counter reset value is INITIAL_CREDITS.
  - Decrements by 1 per accepted legal request, independent of length.
  - Increments on `fsabo_credit`. Both in the same cycle: unchanged.
  - Increment at INITIAL_CREDITS saturates and is ignored.
- FSM states:
  - IDLE -> WBURST on acceptance of a legal write with `req_len` > 1.
  - WBURST -> IDLE when the last beat is loaded.
- `req_ready` is combinational and high only in IDLE with credits != 0, and additionally requires one of:
  - `req_write`=0;
  - `req_len` illegal;
  - buffer count >= `req_len`.
- Illegal length: the request is consumed and `len_err` pulses the next cycle. There is no bus beat, no credit use and no buffer pop.
- Read accept: one beat with `fsabo_mode`=0 and `fsabo_data`=0, `fsabo_mask`=0. The FSM stays in IDLE.
- Write accept: `req_len` beats on consecutive cycles. Each beat pops one buffer entry.
  - Header fields (mode=1, did, subdid, addr, len) are identical on every beat.
  - `fsabo_addr` is not incremented.
- When `fsabo_valid`=0: `fsabo_data`/`fsabo_mask` are 0 and header fields hold their last values.

## Timing
- All `fsabo_*` and `len_err` are registered. Reset values are all 0; credits = INITIAL_CREDITS; buffer empty; FSM in IDLE.
- Accept in cycle N: beat k (1-based) is visible in cycle N+k. A read is visible in N+1.
- Beat k's buffer pop occurs at the edge ending cycle N+k-1.
- The FSM returns to IDLE in cycle N+len, so the next accept may occur in N+len. This gives zero-gap back-to-back bursts.
- Back-to-back reads may be accepted every cycle while credits remain.
- A credit pulse in cycle N allows an accept in N+1 when credits were 0.
- Asynchronous reset mid-burst: `fsabo_valid` drops immediately, the burst is truncated, the buffer is flushed and credits are restored.

## Test plan
- Reset, then 4 reads (addr 0x100..0x103, len 1) with no credit returns -> 4 beats in cycles 1..4 after first accept. 5th read stalls with `req_ready`=0 until an `fsabo_credit` pulse, then issues one cycle later.
- Push 4 beats (0xA0..0xA3, mask 0xFF), write addr 0x2000 len 4 -> 4 contiguous beats, data 0xA0..0xA3, header constant. Count returns to 0 and credits = 3.
- Write len 4 with only 2 beats buffered -> `req_ready`=0 and no beats. After 2 more pushes, accept and a 4-beat burst follow.
- Write len 2 then read, both pending -> the read is accepted in the cycle the FSM re-enters IDLE, with no bubble between the write's last beat and the read beat.
- `req_len`=0 and `req_len`=9 -> `len_err` pulses each time. There is no `fsabo_valid`, and credits and buffer are unchanged.
- Simultaneous accept and `fsabo_credit` -> credits unchanged. `fsabo_credit` at full credits -> credits stay 4.
- Assert `Nrst` during beat 2 of a len-4 write -> all outputs go to 0 immediately. After reset, credits = 4 and `wdata_ready`=1.

Source files
------------

// File: rtl/fsab_client_issuer_if.sv
// fsab_client_issuer_if
// Bundles the client request channel, the write-data stream and the FSAB
// request-beat channel of one issuer.
//   master : the issuer. It drives req_ready, wdata_ready, fsabo_* and len_err.
//   slave  : the environment (client plus arbiter port). It drives the
//            request, the write data and the credit return pulse.
interface fsab_client_issuer_if #(
  parameter int ADDR_W = 31,
  parameter int LEN_W  = 4,
  parameter int DATA_W = 64,
  parameter int MASK_W = 8,
  parameter int DID_W  = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic [MASK_W-1:0] wmask;
  logic              fsabo_valid;
  logic              fsabo_mode;
  logic [DID_W-1:0]  fsabo_did;
  logic [DID_W-1:0]  fsabo_subdid;
  logic [ADDR_W-1:0] fsabo_addr;
  logic [LEN_W-1:0]  fsabo_len;
  logic [DATA_W-1:0] fsabo_data;
  logic [MASK_W-1:0] fsabo_mask;
  logic              fsabo_credit;
  logic              len_err;

  modport master (
    input  req_valid, req_write, req_addr, req_len,
    input  wdata_valid, wdata, wmask, fsabo_credit,
    output req_ready, wdata_ready,
    output fsabo_valid, fsabo_mode, fsabo_did, fsabo_subdid,
    output fsabo_addr, fsabo_len, fsabo_data, fsabo_mask, len_err
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len,
    output wdata_valid, wdata, wmask, fsabo_credit,
    input  req_ready, wdata_ready,
    input  fsabo_valid, fsabo_mode, fsabo_did, fsabo_subdid,
    input  fsabo_addr, fsabo_len, fsabo_data, fsabo_mask, len_err
  );
endinterface

// File: rtl/fsab_client_issuer.sv
// fsab_client_issuer
// Upstream FSAB master stage. It turns client read/write requests and a
// write-data stream into FSAB request beats. A credit counter keeps the
// arbiter's request FIFO from overflowing. Write bursts go out as contiguous
// beats.
// Ports:
//   clk  : clock
//   Nrst : asynchronous active-low reset
//   bus  : fsab_client_issuer_if.master, which carries the request,
//          write-data and fsabo_* channels
module fsab_client_issuer #(
  parameter int DID             = 0,
  parameter int SUBDID          = 0,
  parameter int INITIAL_CREDITS = 4,
  parameter int CREDITS_W       = 3,
  parameter int ADDR_W          = 31,
  parameter int LEN_W           = 4,
  parameter int DATA_W          = 64,
  parameter int MASK_W          = 8,
  parameter int DID_W           = 4,
  parameter int WBUF_DEPTH      = 8
) (
  input logic                  clk,
  input logic                  Nrst,
  fsab_client_issuer_if.master bus
);
  localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;
  localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam logic [CREDITS_W-1:0] CRED_INIT = CREDITS_W'(INITIAL_CREDITS);

  typedef enum logic {IDLE, WBURST} state_e;

  typedef struct packed {
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] data;
  } wbeat_t;

  wbeat_t               mem_q [WBUF_DEPTH];
  wbeat_t               head;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CREDITS_W-1:0] cred_q, cred_d;
  state_e               state_q;
  logic [LEN_W-1:0]     rem_q;

  logic              valid_q, mode_q, err_q;
  logic [DID_W-1:0]  did_q, subdid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] data_q;
  logic [MASK_W-1:0] mask_q;

  logic len_ok, accept, acc_ok, acc_wr, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == WBUF_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign len_ok = (bus.req_len != '0) && (32'(bus.req_len) <= WBUF_DEPTH);

  assign bus.wdata_ready = 32'(cnt_q) < WBUF_DEPTH;
  assign push            = bus.wdata_valid && bus.wdata_ready;

  // A write is accepted only when its whole burst is already buffered.
  // The burst therefore never stalls once it has started.
  assign bus.req_ready = (state_q == IDLE) && (cred_q != '0) &&
                         (!bus.req_write || !len_ok ||
                          32'(cnt_q) >= 32'(bus.req_len));

  assign accept = bus.req_valid && bus.req_ready;
  assign acc_ok = accept && len_ok;
  assign acc_wr = acc_ok && bus.req_write;

  // Every edge that loads a write beat into the output register pops one entry.
  assign pop  = acc_wr || (state_q == WBURST);
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  // An accept and a credit return in the same cycle cancel out.
  always_comb begin
    cred_d = cred_q;
    if (acc_ok && !bus.fsabo_credit)
      cred_d = cred_q - 1'b1;
    else if (!acc_ok && bus.fsabo_credit && cred_q != CRED_INIT)
      cred_d = cred_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.wmask, bus.wdata};
  end

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      cred_q   <= CRED_INIT;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q  <= cnt_d;
      cred_q <= cred_d;
    end
  end

  // The FSM and the registered beat outputs. rem_q counts the burst beats
  // that are still to be loaded after the current one.
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      valid_q  <= 1'b0;
      mode_q   <= 1'b0;
      did_q    <= '0;
      subdid_q <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q   <= accept && !len_ok;
      valid_q <= 1'b0;
      data_q  <= '0;
      mask_q  <= '0;
      case (state_q)
        IDLE: begin
          if (acc_ok) begin
            valid_q  <= 1'b1;
            mode_q   <= bus.req_write;
            did_q    <= DID_W'(DID);
            subdid_q <= DID_W'(SUBDID);
            addr_q   <= bus.req_addr;
            len_q    <= bus.req_len;
            if (bus.req_write) begin
              data_q <= head.data;
              mask_q <= head.mask;
              if (bus.req_len != LEN_W'(1)) begin
                state_q <= WBURST;
                rem_q   <= bus.req_len - 1'b1;
              end
            end
          end
        end
        WBURST: begin
          valid_q <= 1'b1;
          data_q  <= head.data;
          mask_q  <= head.mask;
          rem_q   <= rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.fsabo_valid  = valid_q;
  assign bus.fsabo_mode   = mode_q;
  assign bus.fsabo_did    = did_q;
  assign bus.fsabo_subdid = subdid_q;
  assign bus.fsabo_addr   = addr_q;
  assign bus.fsabo_len    = len_q;
  assign bus.fsabo_data   = data_q;
  assign bus.fsabo_mask   = mask_q;
  assign bus.len_err      = err_q;
endmodule

// File: tb/tb_fsab_client_issuer.sv
// tb_fsab_client_issuer
// Runs the directed scenarios first and then random traffic. A transaction-level
// model follows the DUT: a queue of buffered write beats, a credit count and a
// schedule of beats due on the following cycles. Every cycle the model's
// expectations are compared with the DUT outputs.
module tb_fsab_client_issuer;
  logic clk = 1'b0;
  logic Nrst = 1'b0;
  always #5 clk = ~clk;

  fsab_client_issuer_if bif ();
  fsab_client_issuer dut (.clk(clk), .Nrst(Nrst), .bus(bif));

  typedef struct packed {
    logic        mode;
    logic [30:0] addr;
    logic [3:0]  len;
  } hdr_t;

  int n_chk = 0;
  int n_err = 0;

  // model state
  hdr_t        sched[$];     // beats due on the following cycles, in order
  logic [71:0] wq[$];        // buffered {mask, data}
  int          credits;
  bit          last_acc, last_push;
  logic        e_valid, e_err;
  hdr_t        e_hdr;
  logic [63:0] e_data;
  logic [7:0]  e_mask;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    sched.delete();
    wq.delete();
    credits = 4;
    e_valid = 1'b0;
    e_err   = 1'b0;
    e_hdr   = '0;
    e_data  = '0;
    e_mask  = '0;
  endtask

  // Runs one clock cycle. Inputs are already stable. The bench checks at the
  // negedge, then advances the model at the posedge.
  task automatic step();
    int l;
    bit legal, rdy, wrdy;
    hdr_t h;
    logic [71:0] b;
    @(negedge clk);
    l     = int'(bif.req_len);
    legal = (l >= 1) && (l <= 8);
    rdy   = (sched.size() == 0) && (credits != 0) &&
            (!bif.req_write || !legal || wq.size() >= l);
    wrdy  = wq.size() < 8;
    chk("req_ready",   64'(bif.req_ready),    64'(rdy));
    chk("wdata_ready", 64'(bif.wdata_ready),  64'(wrdy));
    chk("fsabo_valid", 64'(bif.fsabo_valid),  64'(e_valid));
    chk("len_err",     64'(bif.len_err),      64'(e_err));
    chk("fsabo_mode",  64'(bif.fsabo_mode),   64'(e_hdr.mode));
    chk("fsabo_addr",  64'(bif.fsabo_addr),   64'(e_hdr.addr));
    chk("fsabo_len",   64'(bif.fsabo_len),    64'(e_hdr.len));
    chk("fsabo_data",  bif.fsabo_data,        e_data);
    chk("fsabo_mask",  64'(bif.fsabo_mask),   64'(e_mask));
    chk("fsabo_did",   64'(bif.fsabo_did),    64'd0);
    chk("fsabo_sdid",  64'(bif.fsabo_subdid), 64'd0);
    last_acc  = bif.req_valid && rdy;
    last_push = bif.wdata_valid && wrdy;
    @(posedge clk);
    if (last_acc && legal) begin
      h.mode = bif.req_write;
      h.addr = bif.req_addr;
      h.len  = bif.req_len;
      for (int i = 0; i < (bif.req_write ? l : 1); i++) sched.push_back(h);
      if (!bif.fsabo_credit) credits--;
    end else if (bif.fsabo_credit && credits < 4) begin
      credits++;
    end
    e_err = last_acc && !legal;
    if (sched.size() != 0) begin
      e_hdr   = sched.pop_front();
      e_valid = 1'b1;
      if (e_hdr.mode) begin
        b = (wq.size() != 0) ? wq.pop_front() : 72'd0;
        {e_mask, e_data} = b;
      end else begin
        e_data = '0;
        e_mask = '0;
      end
    end else begin
      e_valid = 1'b0;
      e_data  = '0;
      e_mask  = '0;
    end
    if (last_push) wq.push_back({bif.wmask, bif.wdata});
    #1;
  endtask

  task automatic drive_req(input bit wr, input logic [30:0] a, input logic [3:0] l);
    int n = 0;
    bif.req_valid = 1'b1;
    bif.req_write = wr;
    bif.req_addr  = a;
    bif.req_len   = l;
    do begin step(); n++; end while (!last_acc && n < 64);
    chk("req_accept_timeout", 64'(last_acc), 64'd1);
    bif.req_valid = 1'b0;
  endtask

  task automatic push_w(input logic [63:0] d, input logic [7:0] m);
    int n = 0;
    bif.wdata_valid = 1'b1;
    bif.wdata       = d;
    bif.wmask       = m;
    do begin step(); n++; end while (!last_push && n < 64);
    chk("push_timeout", 64'(last_push), 64'd1);
    bif.wdata_valid = 1'b0;
  endtask

  task automatic refill();
    bif.fsabo_credit = 1'b1;
    for (int i = 0; i < 8 && credits < 4; i++) step();
    bif.fsabo_credit = 1'b0;
  endtask

  // Issues four reads, then holds a fifth one that must stall.
  task automatic use_all_credits(input logic [30:0] base);
    for (int i = 0; i < 4; i++) drive_req(1'b0, base + 31'(i), 4'd1);
    bif.req_valid = 1'b1;
    bif.req_addr  = base + 31'd4;
    repeat (2) step();
    bif.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bif.req_valid = 1'b0; bif.req_write = 1'b0; bif.req_addr = '0; bif.req_len = '0;
    bif.wdata_valid = 1'b0; bif.wdata = '0; bif.wmask = '0; bif.fsabo_credit = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    Nrst = 1'b1;
    @(posedge clk);
    #1;
    step();

    // four reads with no credit return, then a fifth that stalls until a credit comes back
    for (int i = 0; i < 4; i++) drive_req(1'b0, 31'h100 + 31'(i), 4'd1);
    bif.req_valid = 1'b1; bif.req_write = 1'b0; bif.req_addr = 31'h104; bif.req_len = 4'd1;
    repeat (3) step();
    bif.fsabo_credit = 1'b1;
    step();
    bif.fsabo_credit = 1'b0;
    drive_req(1'b0, 31'h104, 4'd1);
    step();
    refill();

    // a four-beat write burst from a full buffer
    for (int i = 0; i < 4; i++) push_w(64'hA0 + 64'(i), 8'hFF);
    drive_req(1'b1, 31'h2000, 4'd4);
    repeat (5) step();
    refill();

    // a write of length 4 with only 2 beats buffered must wait
    push_w(64'hB0, 8'h0F);
    push_w(64'hB1, 8'hF0);
    bif.req_valid = 1'b1; bif.req_write = 1'b1; bif.req_addr = 31'h2400; bif.req_len = 4'd4;
    repeat (3) step();
    push_w(64'hB2, 8'h3C);
    push_w(64'hB3, 8'hC3);
    drive_req(1'b1, 31'h2400, 4'd4);
    repeat (5) step();
    refill();

    // a write of length 2 followed at once by a read: no bubble between them
    push_w(64'hC0, 8'h11);
    push_w(64'hC1, 8'h22);
    drive_req(1'b1, 31'h2800, 4'd2);
    drive_req(1'b0, 31'h2900, 4'd1);
    repeat (3) step();
    refill();

    // illegal lengths are consumed with len_err and nothing else
    drive_req(1'b1, 31'h40, 4'd0);
    drive_req(1'b0, 31'h41, 4'd9);
    drive_req(1'b1, 31'h42, 4'd9);
    repeat (2) step();
    use_all_credits(31'h600);
    refill();

    // an accept and a credit in the same cycle; a credit while at full credits
    drive_req(1'b0, 31'h500, 4'd1);
    bif.fsabo_credit = 1'b1;
    drive_req(1'b0, 31'h501, 4'd1);
    bif.fsabo_credit = 1'b0;
    step();
    refill();
    bif.fsabo_credit = 1'b1;
    repeat (2) step();
    bif.fsabo_credit = 1'b0;
    use_all_credits(31'h700);
    refill();

    // asynchronous reset during beat 2 of a four-beat write
    for (int i = 0; i < 4; i++) push_w(64'hD0 + 64'(i), 8'hAA);
    drive_req(1'b1, 31'h3000, 4'd4);
    step();
    #2 Nrst = 1'b0;
    #1;
    chk("rst_valid", 64'(bif.fsabo_valid), 64'd0);
    chk("rst_mode",  64'(bif.fsabo_mode),  64'd0);
    chk("rst_addr",  64'(bif.fsabo_addr),  64'd0);
    chk("rst_len",   64'(bif.fsabo_len),   64'd0);
    chk("rst_data",  bif.fsabo_data,       64'd0);
    chk("rst_mask",  64'(bif.fsabo_mask),  64'd0);
    chk("rst_wrdy",  64'(bif.wdata_ready), 64'd1);
    bif.req_valid = 1'b0; bif.wdata_valid = 1'b0; bif.fsabo_credit = 1'b0;
    model_reset();
    @(negedge clk);
    Nrst = 1'b1;
    @(posedge clk);
    #1;
    step();
    use_all_credits(31'h800);
    refill();

    // random traffic
    for (int c = 0; c < 800; c++) begin
      if (!bif.req_valid || last_acc || $urandom_range(7) == 0) begin
        bif.req_valid = ($urandom_range(2) != 0);
        bif.req_write = 1'($urandom_range(1));
        bif.req_addr  = 31'($urandom);
        if ($urandom_range(9) == 0)
          bif.req_len = ($urandom_range(1) != 0) ? 4'd0 : 4'd9 + 4'($urandom_range(6));
        else
          bif.req_len = 4'($urandom_range(8, 1));
      end
      bif.wdata_valid  = 1'($urandom_range(1));
      bif.wdata        = {$urandom, $urandom};
      bif.wmask        = 8'($urandom);
      bif.fsabo_credit = (credits < 4) && ($urandom_range(2) == 0);
      step();
    end
    bif.req_valid = 1'b0; bif.wdata_valid = 1'b0; bif.fsabo_credit = 1'b0;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
